// File: rtl/johnson_pkg.sv
// Shared types and Johnson-code helper functions. The functions take the
// code zero-extended to 32 bits plus the live width n (2 <= n <= 32).
package johnson_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_e;

  localparam int MAX_N = 32;

  // Expected next code: shift left, feed back the inverted MSB.
  function automatic logic [31:0] johnson_succ(input logic [31:0] code, input int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    return ((code << 1) | {31'd0, ~code[n-1]}) & mask;
  endfunction

  // Legal codes are ones right-aligned or ones left-aligned within n bits.
  function automatic logic johnson_legal(input logic [31:0] code, input int n);
    logic [31:0] mask;
    logic [31:0] low;
    logic        ok;
    mask = (32'd1 << n) - 32'd1;
    ok   = 1'b0;
    for (int k = 0; k <= MAX_N; k++) begin
      if (k <= n) begin
        low = (32'd1 << k) - 32'd1;
        if (code == low) ok = 1'b1;
        if (code == (mask & ~(mask >> k))) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  // Phase index: popcount while the MSB is clear, 2n - popcount once it is set.
  function automatic logic [31:0] johnson_decode(input logic [31:0] code, input int n);
    int pop;
    pop = 0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) pop = pop + int'(code[k]);
    end
    if (code[n-1]) return 32'(2 * n - pop);
    return 32'(pop);
  endfunction

endpackage

// File: rtl/johnson_phase_tracker_check.sv
// Combinational code checker: legality, decoded phase, successor match.
import johnson_pkg::*;

module johnson_code_check #(
  parameter  int N  = 4,
  localparam int PW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code_in,
  input  logic [N-1:0]  prev,
  output logic          legal,
  output logic [PW-1:0] phase,
  output logic          succ_match
);

  assign legal      = johnson_legal(32'(code_in), N);
  assign phase      = PW'(johnson_decode(32'(code_in), N));
  assign succ_match = (code_in == N'(johnson_succ(32'(prev), N)));

endmodule

// File: rtl/johnson_phase_tracker.sv
// Johnson phase tracker: samples the upstream Johnson code, checks legality
// and sequence, decodes the phase, tracks lock and counts errors.
//
//   state   | meaning
//   ACQUIRE | collecting clean successor transitions, not yet trusted
//   LOCKED  | LOCK_CNT clean transitions seen; stays until an error
import johnson_pkg::*;

module johnson_phase_tracker #(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int ERR_W    = 8,
  localparam int PW       = $clog2(2 * N),
  localparam int RW       = $clog2(LOCK_CNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     code_in,
  input  logic             code_vld,
  input  logic             clr_err,
  output logic [PW-1:0]    phase,
  output logic             phase_vld,
  output logic             wrap,
  output logic             locked,
  output logic             illegal,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_cnt
);

  state_e           state_q, state_d;
  logic [N-1:0]     prev_q, prev_d;
  logic             has_prev_q, has_prev_d;
  logic [RW-1:0]    run_q, run_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             phase_vld_q, phase_vld_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_event;

  logic             legal_c;
  logic [PW-1:0]    phase_c;
  logic             match_c;

  johnson_code_check #(.N(N)) u_check (
    .code_in    (code_in),
    .prev       (prev_q),
    .legal      (legal_c),
    .phase      (phase_c),
    .succ_match (match_c)
  );

  // Per-sample evaluation, lock FSM next state and error counter update.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    has_prev_d  = has_prev_q;
    run_d       = run_q;
    phase_d     = phase_q;
    phase_vld_d = 1'b0;
    wrap_d      = 1'b0;
    illegal_d   = 1'b0;
    seq_err_d   = 1'b0;
    err_d       = err_q;
    err_event   = 1'b0;

    if (code_vld) begin
      if (!legal_c) begin
        // prev is kept but no longer trusted as a predecessor
        illegal_d  = 1'b1;
        has_prev_d = 1'b0;
        run_d      = '0;
        err_event  = 1'b1;
      end else begin
        phase_vld_d = 1'b1;
        phase_d     = phase_c;
        prev_d      = code_in;
        has_prev_d  = 1'b1;
        if (!has_prev_q) begin
          run_d = '0;
        end else if (match_c) begin
          if (run_q != RW'(LOCK_CNT)) run_d = run_q + 1'b1;
          wrap_d = (phase_q == PW'(2 * N - 1)) && (phase_c == '0);
        end else begin
          seq_err_d = 1'b1;
          run_d     = '0;
          err_event = 1'b1;
        end
      end
    end

    case (state_q)
      ACQUIRE: if (run_d == RW'(LOCK_CNT)) state_d = LOCKED;
      LOCKED:  if (illegal_d || seq_err_d) state_d = ACQUIRE;
      default: state_d = ACQUIRE;
    endcase

    if (clr_err) err_d = '0;
    else if (err_event && (err_q != '1)) err_d = err_q + 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACQUIRE;
      prev_q      <= '0;
      has_prev_q  <= 1'b0;
      run_q       <= '0;
      phase_q     <= '0;
      phase_vld_q <= 1'b0;
      wrap_q      <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      has_prev_q  <= has_prev_d;
      run_q       <= run_d;
      phase_q     <= phase_d;
      phase_vld_q <= phase_vld_d;
      wrap_q      <= wrap_d;
      illegal_q   <= illegal_d;
      seq_err_q   <= seq_err_d;
      err_q       <= err_d;
    end
  end

  assign phase     = phase_q;
  assign phase_vld = phase_vld_q;
  assign wrap      = wrap_q;
  assign locked    = (state_q == LOCKED);
  assign illegal   = illegal_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed bench for johnson_phase_tracker (N=4, LOCK_CNT=3, ERR_W=8).
module tb_johnson_phase_tracker;

  logic       clk;
  logic       rst;
  logic [3:0] code_in;
  logic       code_vld;
  logic       clr_err;
  logic [2:0] phase;
  logic       phase_vld;
  logic       wrap;
  logic       locked;
  logic       illegal;
  logic       seq_err;
  logic [7:0] err_cnt;

  int n_chk = 0;
  int n_err = 0;

  johnson_phase_tracker #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_vld  (code_vld),
    .clr_err   (clr_err),
    .phase     (phase),
    .phase_vld (phase_vld),
    .wrap      (wrap),
    .locked    (locked),
    .illegal   (illegal),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ph, input bit pv, input bit wr,
                           input bit lk, input bit il, input bit se, input int ec);
    check({tag, ".phase"},     32'(phase),     32'(ph));
    check({tag, ".phase_vld"}, 32'(phase_vld), 32'(pv));
    check({tag, ".wrap"},      32'(wrap),      32'(wr));
    check({tag, ".locked"},    32'(locked),    32'(lk));
    check({tag, ".illegal"},   32'(illegal),   32'(il));
    check({tag, ".seq_err"},   32'(seq_err),   32'(se));
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(ec));
  endtask

  // Drive one cycle of inputs at the falling edge; outputs settle #1 after the rising edge.
  task automatic drive(input logic [3:0] c, input logic v, input logic clr);
    @(negedge clk);
    code_in  = c;
    code_vld = v;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [3:0] c, input int ph, input bit pv,
                     input bit wr, input bit lk, input bit il, input bit se, input int ec);
    drive(c, 1'b1, 1'b0);
    check_all(tag, ph, pv, wr, lk, il, se, ec);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    code_vld = 1'b0;
    #2 rst = 1'b0;
    #1 check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    code_in  = 4'b0000;
    code_vld = 1'b0;
    clr_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all("rst_init", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1. reset mid-stream, then first sample has no predecessor
    vec("pre0", 4'b0000, 0, 1, 0, 0, 0, 0, 0);
    vec("pre1", 4'b0001, 1, 1, 0, 0, 0, 0, 0);
    pulse_reset();
    vec("post_rst", 4'b0011, 2, 1, 0, 0, 0, 0, 0);
    pulse_reset();

    // 2. lock acquisition
    vec("lock0", 4'b0000, 0, 1, 0, 0, 0, 0, 0);
    vec("lock1", 4'b0001, 1, 1, 0, 0, 0, 0, 0);
    vec("lock2", 4'b0011, 2, 1, 0, 0, 0, 0, 0);
    vec("lock3", 4'b0111, 3, 1, 0, 1, 0, 0, 0);

    // 3. wrap
    vec("wrap4", 4'b1111, 4, 1, 0, 1, 0, 0, 0);
    vec("wrap5", 4'b1110, 5, 1, 0, 1, 0, 0, 0);
    vec("wrap6", 4'b1100, 6, 1, 0, 1, 0, 0, 0);
    vec("wrap7", 4'b1000, 7, 1, 0, 1, 0, 0, 0);
    vec("wrap0", 4'b0000, 0, 1, 1, 1, 0, 0, 0);

    // 4. illegal code while locked, then relock from scratch
    vec("ill",   4'b0101, 0, 0, 0, 0, 1, 0, 1);
    vec("rel1",  4'b0001, 1, 1, 0, 0, 0, 0, 1);
    vec("rel2",  4'b0011, 2, 1, 0, 0, 0, 0, 1);
    vec("rel3",  4'b0111, 3, 1, 0, 0, 0, 0, 1);
    vec("rel4",  4'b1111, 4, 1, 0, 1, 0, 0, 1);

    // 5. skip while locked
    vec("run5",  4'b1110, 5, 1, 0, 1, 0, 0, 1);
    vec("run6",  4'b1100, 6, 1, 0, 1, 0, 0, 1);
    vec("run7",  4'b1000, 7, 1, 0, 1, 0, 0, 1);
    vec("run0",  4'b0000, 0, 1, 1, 1, 0, 0, 1);
    vec("run1",  4'b0001, 1, 1, 0, 1, 0, 0, 1);
    vec("run2",  4'b0011, 2, 1, 0, 1, 0, 0, 1);
    vec("skip",  4'b1111, 4, 1, 0, 0, 0, 1, 2);
    vec("rs5",   4'b1110, 5, 1, 0, 0, 0, 0, 2);
    vec("rs6",   4'b1100, 6, 1, 0, 0, 0, 0, 2);
    vec("rs7",   4'b1000, 7, 1, 0, 1, 0, 0, 2);

    // 6. error counter saturation, clear priority, idle gaps
    for (int i = 0; i < 300; i++) drive(4'b0101, 1'b1, 1'b0);
    check_all("sat", 7, 0, 0, 0, 1, 0, 255);
    vec("sat_first", 4'b0000, 0, 1, 0, 0, 0, 0, 255);
    drive(4'b0000, 1'b1, 1'b1);
    check_all("clr_rep", 0, 1, 0, 0, 0, 1, 0);
    drive(4'b0000, 1'b0, 1'b1);
    check_all("clr_idle", 0, 0, 0, 0, 0, 0, 0);

    vec("gap1", 4'b0001, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0101, 1'b0, 1'b0);
      check_all("idle_a", 1, 0, 0, 0, 0, 0, 0);
    end
    vec("gap2", 4'b0011, 2, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(4'b1010, 1'b0, 1'b0);
    check_all("idle_b", 2, 0, 0, 0, 0, 0, 0);
    vec("gap3", 4'b0111, 3, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(4'b0101, 1'b0, 1'b0);
      check_all("idle_lk", 3, 0, 0, 1, 0, 0, 0);
    end
    vec("gap4", 4'b1111, 4, 1, 0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
